mega_sprite_render: RTL and testbench

- Downstream consumer of the Megaman sprite RAM (12-bit colour, 4096 entries, 1-cycle registered read).
- Takes the current scan pixel (x, y) from the frame counter and computes the RAM read address: 4 animation frames of 32x32, optional horizontal mirror.
- Applies chroma-key transparency and overlays the sprite on the incoming background stream. The result goes to the next video stage.
- CPU-visible registers set position, control and animation rate.

---
 rtl/mega_sprite_pkg.sv | 24 ++
 rtl/mega_anim_ctr.sv | 48 ++++
 rtl/mega_sprite_render.sv | 142 ++++++++++++++
 tb/tb_mega_sprite_render.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mega_sprite_pkg.sv
// Shared definitions for the Megaman sprite renderer.
//   - CPU register addresses
//   - ctrl register bit positions and the packed ctrl_t view of that register
package mega_sprite_pkg;

  localparam logic [1:0] REG_X0   = 2'd0;
  localparam logic [1:0] REG_Y0   = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_DIV  = 2'd3;

  localparam int unsigned CTRL_ANIM_EN  = 0;
  localparam int unsigned CTRL_MIRROR   = 1;
  localparam int unsigned CTRL_FRAME_LO = 2;
  localparam int unsigned CTRL_FRAME_HI = 3;
  localparam int unsigned CTRL_BYPASS   = 4;

  typedef struct packed {
    logic       bypass;
    logic [1:0] frame;
    logic       mirror;
    logic       anim_en;
  } ctrl_t;

endpackage

// File: rtl/mega_anim_ctr.sv
// Animation frame sequencer.
//   clk, reset_n : clock, async active-low reset
//   frame_tick   : one-cycle pulse at the start of each video frame
//   anim_en      : 1 = auto-advance, 0 = frame follows frame_sel on each tick
//   frame_sel    : manual frame select
//   anim_div     : ticks per animation frame (0 behaves as 1)
//   frame_idx    : current animation frame
module mega_anim_ctr #(
  parameter int unsigned FRAME_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_tick,
  input  logic                  anim_en,
  input  logic [FRAME_BITS-1:0] frame_sel,
  input  logic [7:0]            anim_div,
  output logic [FRAME_BITS-1:0] frame_idx
);

  logic [7:0]            cnt_q;
  logic [7:0]            cnt_last;
  logic [FRAME_BITS-1:0] frame_q;

  // Divider of 0 is treated as 1 so the counter always rolls over.
  always_comb begin
    cnt_last = (anim_div == 8'd0) ? 8'd0 : anim_div - 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      frame_q <= '0;
    end else if (!anim_en) begin
      cnt_q <= '0;
      if (frame_tick) frame_q <= frame_sel;
    end else if (frame_tick) begin
      if (cnt_q == cnt_last) begin
        cnt_q   <= '0;
        frame_q <= frame_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign frame_idx = frame_q;

endmodule

// File: rtl/mega_sprite_render.sv
// Sprite overlay stage: computes the sprite RAM address for the current scan pixel,
// applies chroma-key transparency and composites the sprite over the background.
//   clk, reset_n               : clock, async active-low reset
//   wr_en, reg_addr, wr_data   : CPU register writes (x0, y0, ctrl, anim_div)
//   x, y, frame_tick           : scan position and frame start pulse
//   si_rgb                     : background pixel in
//   ram_addr_r, ram_dout       : sprite RAM address (registered) and its read data
//   so_rgb, sprite_hit         : composited pixel and opaque-sprite flag, 2 clk after input
module mega_sprite_render
  import mega_sprite_pkg::*;
#(
  parameter int unsigned    CD           = 12,
  parameter int unsigned    ADDR_WIDTH   = 12,
  parameter int unsigned    SIZE_BITS    = 5,
  parameter int unsigned    FRAME_BITS   = 2,
  parameter logic [CD-1:0]  KEY_COLOR    = 12'hF0F,
  parameter logic [7:0]     ANIM_DIV_RST = 8'd8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [1:0]            reg_addr,
  input  logic [31:0]           wr_data,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic                  frame_tick,
  input  logic [CD-1:0]         si_rgb,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [CD-1:0]         ram_dout,
  output logic [CD-1:0]         so_rgb,
  output logic                  sprite_hit
);

  localparam logic [11:0] SpriteEdge = 12'(1 << SIZE_BITS);

  logic [10:0]           x0_sh, y0_sh, x0_q, y0_q;
  logic [10:0]           x0_nxt, y0_nxt;
  ctrl_t                 ctrl_q;
  logic [7:0]            div_q;
  logic [FRAME_BITS-1:0] frame_idx;

  logic                  unused_wr_data;
  assign unused_wr_data = ^wr_data[31:11];

  // CPU registers. Active position is only reloaded at frame start; a write landing
  // on the same cycle as frame_tick goes straight through to the active copy.
  always_comb begin
    x0_nxt = (wr_en && reg_addr == REG_X0) ? wr_data[10:0] : x0_sh;
    y0_nxt = (wr_en && reg_addr == REG_Y0) ? wr_data[10:0] : y0_sh;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_sh  <= '0;
      y0_sh  <= '0;
      x0_q   <= '0;
      y0_q   <= '0;
      ctrl_q <= '0;
      div_q  <= ANIM_DIV_RST;
    end else begin
      if (wr_en) begin
        case (reg_addr)
          REG_X0:   x0_sh <= wr_data[10:0];
          REG_Y0:   y0_sh <= wr_data[10:0];
          REG_CTRL: ctrl_q <= '{bypass:  wr_data[CTRL_BYPASS],
                                frame:   wr_data[CTRL_FRAME_HI:CTRL_FRAME_LO],
                                mirror:  wr_data[CTRL_MIRROR],
                                anim_en: wr_data[CTRL_ANIM_EN]};
          REG_DIV:  div_q <= wr_data[7:0];
          default:  ;
        endcase
      end
      if (frame_tick) begin
        x0_q <= x0_nxt;
        y0_q <= y0_nxt;
      end
    end
  end

  mega_anim_ctr #(
    .FRAME_BITS (FRAME_BITS)
  ) u_anim_ctr (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .anim_en    (ctrl_q.anim_en),
    .frame_sel  (ctrl_q.frame),
    .anim_div   (div_q),
    .frame_idx  (frame_idx)
  );

  // Stage 0: hit test and address. 12-bit offsets so a sprite near the right or
  // bottom edge is clipped instead of wrapping to column/row 0.
  logic [11:0]           dx, dy;
  logic                  in_reg;
  logic [SIZE_BITS-1:0]  col, row;
  logic [ADDR_WIDTH-1:0] ram_addr_d;

  always_comb begin
    dx     = {1'b0, x} - {1'b0, x0_q};
    dy     = {1'b0, y} - {1'b0, y0_q};
    in_reg = (x >= x0_q) && (y >= y0_q) && (dx < SpriteEdge) && (dy < SpriteEdge);
    // 31 - dx for a 5-bit field is its bitwise inverse.
    col        = ctrl_q.mirror ? ~dx[SIZE_BITS-1:0] : dx[SIZE_BITS-1:0];
    row        = dy[SIZE_BITS-1:0];
    ram_addr_d = {frame_idx, row, col};
  end

  // Stage 1: address to RAM, hit flag and background held alongside.
  logic          in_reg_d1;
  logic [CD-1:0] si_rgb_d1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr_r <= '0;
      in_reg_d1  <= 1'b0;
      si_rgb_d1  <= '0;
    end else begin
      ram_addr_r <= ram_addr_d;
      in_reg_d1  <= in_reg;
      si_rgb_d1  <= si_rgb;
    end
  end

  // Stage 2: chroma key and composite.
  logic opaque;

  always_comb begin
    opaque = in_reg_d1 && (ram_dout != KEY_COLOR) && !ctrl_q.bypass;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      so_rgb     <= '0;
      sprite_hit <= 1'b0;
    end else begin
      so_rgb     <= opaque ? ram_dout : si_rgb_d1;
      sprite_hit <= opaque;
    end
  end

endmodule

// File: tb/tb_mega_sprite_render.sv
// Bench for mega_sprite_render: directed pixels with hand-computed expectations are
// queued by the stimulus process; a monitor pops them when the pixel reaches the
// address stage (1 clk) and the output stage (2 clk).
module tb_mega_sprite_render;
  import mega_sprite_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [1:0]  reg_addr;
  logic [31:0] wr_data;
  logic [10:0] x, y;
  logic        frame_tick;
  logic [11:0] si_rgb;
  logic [11:0] ram_addr_r;
  logic [11:0] ram_dout;
  logic [11:0] so_rgb;
  logic        sprite_hit;

  mega_sprite_render u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .reg_addr   (reg_addr),
    .wr_data    (wr_data),
    .x          (x),
    .y          (y),
    .frame_tick (frame_tick),
    .si_rgb     (si_rgb),
    .ram_addr_r (ram_addr_r),
    .ram_dout   (ram_dout),
    .so_rgb     (so_rgb),
    .sprite_hit (sprite_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sprite RAM model: data belongs to the registered address of the same cycle.
  logic [11:0] mem [4096];
  assign ram_dout = mem[ram_addr_r];

  typedef struct packed {logic en; logic [11:0] addr;} addr_exp_t;
  typedef struct packed {logic [11:0] rgb; logic hit;} pix_exp_t;
  addr_exp_t addr_q [$];
  pix_exp_t  pix_q  [$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
  endtask

  // Tag pipeline marking which cycles carry a checked pixel.
  logic chk, chk_d1, chk_d2;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_d1 <= 1'b0;
      chk_d2 <= 1'b0;
    end else begin
      chk_d1 <= chk;
      chk_d2 <= chk_d1;
    end
  end

  always @(negedge clk) begin
    addr_exp_t ae;
    pix_exp_t  pe;
    if (chk_d1) begin
      if (addr_q.size() == 0) check("addr queue underrun", 1, 0);
      else begin
        ae = addr_q.pop_front();
        if (ae.en) check("ram_addr_r", 32'(ram_addr_r), 32'(ae.addr));
      end
    end
    if (chk_d2) begin
      if (pix_q.size() == 0) check("pixel queue underrun", 1, 0);
      else begin
        pe = pix_q.pop_front();
        check("so_rgb", 32'(so_rgb), 32'(pe.rgb));
        check("sprite_hit", 32'(sprite_hit), 32'(pe.hit));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    wr_en = 1'b0; frame_tick = 1'b0; chk = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step();
    wr_en = 1'b1; reg_addr = a; wr_data = d;
  endtask

  task automatic tick();
    step();
    frame_tick = 1'b1;
  endtask

  task automatic wr_tick(input logic [1:0] a, input logic [31:0] d);
    step();
    wr_en = 1'b1; reg_addr = a; wr_data = d; frame_tick = 1'b1;
  endtask

  task automatic pix(input logic [10:0] px, input logic [10:0] py, input logic [11:0] bg,
                     input logic ca, input logic [11:0] ea,
                     input logic [11:0] ergb, input logic ehit);
    step();
    x = px; y = py; si_rgb = bg; chk = 1'b1;
    addr_q.push_back('{en: ca, addr: ea});
    pix_q.push_back('{rgb: ergb, hit: ehit});
  endtask

  logic [1:0]  seq  [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                             2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
  logic [11:0] fcol [4]  = '{12'h123, 12'h111, 12'hA5A, 12'h222};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 12'h000;
    mem[12'h000] = 12'h123; mem[12'h3FF] = 12'h7E1; mem[12'h021] = 12'hF0F;
    mem[12'h03F] = 12'h456; mem[12'h020] = 12'h789; mem[12'h400] = 12'h111;
    mem[12'h800] = 12'hA5A; mem[12'hC00] = 12'h222; mem[12'h01F] = 12'h0AA;
    mem[12'h011] = 12'h0BB; mem[12'h0E5] = 12'h0CC;

    reset_n = 1'b0; wr_en = 1'b0; reg_addr = '0; wr_data = '0;
    x = '0; y = '0; frame_tick = 1'b0; si_rgb = '0; chk = 1'b0;
    #23;
    check("reset so_rgb", 32'(so_rgb), 0);
    check("reset sprite_hit", 32'(sprite_hit), 0);
    check("reset ram_addr_r", 32'(ram_addr_r), 0);
    reset_n = 1'b1;

    // Place sprite at (100,50).
    wr(REG_X0, 100);
    wr(REG_Y0, 50);
    tick();
    pix(100, 50, 12'h555, 1, 12'h000, 12'h123, 1);
    // Outside the region and at its far corner.
    pix(99, 60, 12'hABC, 0, 12'h000, 12'hABC, 0);
    pix(132, 60, 12'hABC, 0, 12'h000, 12'hABC, 0);
    pix(131, 81, 12'h111, 1, 12'h3FF, 12'h7E1, 1);
    pix(100, 82, 12'h222, 0, 12'h000, 12'h222, 0);
    // Chroma key passes the background.
    pix(101, 51, 12'h0F0, 1, 12'h021, 12'h0F0, 0);
    idle(2);

    // Mirror on/off.
    wr(REG_CTRL, 32'h2);
    pix(100, 51, 12'h000, 1, 12'h03F, 12'h456, 1);
    idle(2);
    wr(REG_CTRL, 32'h0);
    pix(100, 51, 12'h000, 1, 12'h020, 12'h789, 1);
    idle(2);

    // Bypass forces the background.
    wr(REG_CTRL, 32'h10);
    pix(100, 50, 12'h321, 1, 12'h000, 12'h321, 0);
    idle(2);

    // Manual frame select takes effect on the next tick.
    wr(REG_CTRL, 32'h8);
    tick();
    pix(100, 50, 12'h000, 1, 12'h800, 12'hA5A, 1);
    idle(2);
    wr(REG_CTRL, 32'h0);
    tick();

    // Auto animation, divider 3.
    wr(REG_DIV, 3);
    wr(REG_CTRL, 32'h1);
    for (int i = 0; i < 12; i++) begin
      tick();
      pix(100, 50, 12'h000, 1, {seq[i], 10'd0}, fcol[seq[i]], 1);
    end
    // Divider 0 advances on every tick.
    wr(REG_DIV, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      pix(100, 50, 12'h000, 1, {2'(i), 10'd0}, fcol[2'(i)], 1);
    end
    wr(REG_CTRL, 32'h0);
    tick();
    idle(2);

    // Shadow x0 only moves the sprite at frame start.
    wr(REG_X0, 200);
    pix(100, 50, 12'h333, 1, 12'h000, 12'h123, 1);
    pix(200, 50, 12'h333, 0, 12'h000, 12'h333, 0);
    tick();
    pix(200, 50, 12'h333, 1, 12'h000, 12'h123, 1);
    pix(231, 50, 12'h333, 1, 12'h01F, 12'h0AA, 1);
    pix(100, 50, 12'h333, 0, 12'h000, 12'h333, 0);

    // Write-through on tick, right-edge clipping with no wrap.
    wr_tick(REG_X0, 2030);
    pix(2047, 50, 12'h444, 1, 12'h011, 12'h0BB, 1);
    pix(0, 50, 12'h444, 0, 12'h000, 12'h444, 0);
    pix(13, 50, 12'h444, 0, 12'h000, 12'h444, 0);
    pix(2047, 50, 12'h444, 1, 12'h011, 12'h0BB, 1);
    idle(3);

    // Async reset mid-scan while the sprite is still being output.
    #2;
    reset_n = 1'b0;
    #1;
    check("mid reset so_rgb", 32'(so_rgb), 0);
    check("mid reset sprite_hit", 32'(sprite_hit), 0);
    check("mid reset ram_addr_r", 32'(ram_addr_r), 0);
    #3;
    reset_n = 1'b1;
    // Registers are back at 0, so the sprite sits at the origin.
    pix(5, 7, 12'h666, 1, 12'h0E5, 12'h0CC, 1);
    idle(4);

    check("addr queue drained", 32'(addr_q.size()), 0);
    check("pixel queue drained", 32'(pix_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
